constrained_rand_point_gen: RTL and testbench

- Parametrised successor to the game's fixed-range dual-LFSR coordinate source.
- Two W-bit Galois LFSRs produce an (X,Y) point within independent inclusive ranges [X_MIN,X_MAX] and [Y_MIN,Y_MAX].
- Points are produced by rejection sampling, with a bounded retry count and a clamp fallback.
- Requests use a Req/Valid/Ack handshake. Consumers are the fruit/power-up spawn logic and ghost scatter-target logic.
- Runtime seed loading lets game-start seeds drive the sequence.

---
 rtl/constrained_rand_point_gen.sv | 203 ++++++++++++++++++++
 tb/tb_constrained_rand_point_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/constrained_rand_point_gen.sv
// Constrained random (X,Y) point generator.
// Two Galois LFSRs are sampled against independent inclusive ranges. Each axis
// latches its first in-range candidate. If an axis is still unlatched after
// MAX_TRIES search cycles, it is clamped to the nearest bound and Fallback is set.
// Results are handed over with a Req/Valid/Ack handshake.
//
// state  | meaning
// IDLE   | waiting for Req; outputs hold the last point, Valid low
// SEARCH | sampling LFSR candidates, LFSRs stepping every cycle
// DONE   | point presented with Valid high, waiting for Ack
module constrained_rand_point_gen #(
    parameter int unsigned    W          = 10,
    parameter logic [W-1:0]   TAPS       = 10'h240,
    parameter int unsigned    X_MIN      = 120,
    parameter int unsigned    X_MAX      = 520,
    parameter int unsigned    Y_MIN      = 48,
    parameter int unsigned    Y_MAX      = 448,
    parameter int unsigned    X_SEED_DEF = 1,
    parameter int unsigned    Y_SEED_DEF = 2,
    parameter int unsigned    MAX_TRIES  = 16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Seed_load,
    input  logic [W-1:0] X_seed,
    input  logic [W-1:0] Y_seed,
    input  logic         Req,
    input  logic         Ack,
    output logic         Valid,
    output logic [W-1:0] X_rand,
    output logic [W-1:0] Y_rand,
    output logic         Fallback,
    output logic         Busy
);

    localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [W-1:0]  XMIN     = W'(X_MIN);
    localparam logic [W-1:0]  XMAX     = W'(X_MAX);
    localparam logic [W-1:0]  YMIN     = W'(Y_MIN);
    localparam logic [W-1:0]  YMAX     = W'(Y_MAX);
    localparam logic [W-1:0]  XSEED    = W'(X_SEED_DEF);
    localparam logic [W-1:0]  YSEED    = W'(Y_SEED_DEF);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);

    // Reject parameter sets that would need wrap-around or could lock up an LFSR.
    if (X_MAX >= (2 ** W) || Y_MAX >= (2 ** W)) begin : g_bad_max
        $error("constrained_rand_point_gen: X_MAX/Y_MAX must be below 2^W");
    end
    if (X_MIN > X_MAX || Y_MIN > Y_MAX) begin : g_bad_range
        $error("constrained_rand_point_gen: MIN must not exceed MAX");
    end
    if (X_SEED_DEF == 0 || Y_SEED_DEF == 0 ||
        X_SEED_DEF >= (2 ** W) || Y_SEED_DEF >= (2 ** W)) begin : g_bad_seed
        $error("constrained_rand_point_gen: default seeds must be non-zero and fit in W bits");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("constrained_rand_point_gen: MAX_TRIES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  lfsr_x_q, lfsr_x_d;
    logic [W-1:0]  lfsr_y_q, lfsr_y_d;
    logic [W-1:0]  x_rand_q, x_rand_d;
    logic [W-1:0]  y_rand_q, y_rand_d;
    logic          fallback_q, fallback_d;
    logic          x_lat_q, x_lat_d;
    logic          y_lat_q, y_lat_d;
    logic [TW-1:0] try_q, try_d;

    logic x_in, y_in, both_done, last_try, start;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Candidate qualification against the inclusive ranges.
    always_comb begin
        x_in      = (lfsr_x_q >= XMIN) && (lfsr_x_q <= XMAX);
        y_in      = (lfsr_y_q >= YMIN) && (lfsr_y_q <= YMAX);
        both_done = (x_lat_q || x_in) && (y_lat_q || y_in);
        last_try  = (try_q == TRY_LAST);
        start     = ((state_q == S_IDLE) && Req) || ((state_q == S_DONE) && Ack && Req);
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; seed loading overrides everything.
    always_comb begin
        state_d = state_q;
        if (Seed_load) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (Req) state_d = S_SEARCH;
                S_SEARCH: if (both_done || last_try) state_d = S_DONE;
                S_DONE:   if (Ack) state_d = Req ? S_SEARCH : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        Busy  = (state_q == S_SEARCH);
        Valid = (state_q == S_DONE);
    end

    // Datapath next values: LFSR stepping, per-axis latching, clamp fallback.
    always_comb begin
        lfsr_x_d   = lfsr_x_q;
        lfsr_y_d   = lfsr_y_q;
        x_rand_d   = x_rand_q;
        y_rand_d   = y_rand_q;
        fallback_d = fallback_q;
        x_lat_d    = x_lat_q;
        y_lat_d    = y_lat_q;
        try_d      = try_q;
        if (Seed_load) begin
            lfsr_x_d   = (X_seed == '0) ? W'(1) : X_seed;
            lfsr_y_d   = (Y_seed == '0) ? W'(1) : Y_seed;
            fallback_d = 1'b0;
            x_lat_d    = 1'b0;
            y_lat_d    = 1'b0;
            try_d      = '0;
        end else if (start) begin
            fallback_d = 1'b0;
            x_lat_d    = 1'b0;
            y_lat_d    = 1'b0;
            try_d      = '0;
        end else if (state_q == S_SEARCH) begin
            lfsr_x_d = lfsr_step(lfsr_x_q);
            lfsr_y_d = lfsr_step(lfsr_y_q);
            if (!x_lat_q && x_in) begin
                x_rand_d = lfsr_x_q;
                x_lat_d  = 1'b1;
            end
            if (!y_lat_q && y_in) begin
                y_rand_d = lfsr_y_q;
                y_lat_d  = 1'b1;
            end
            if (!both_done) begin
                if (last_try) begin
                    // Out-of-range unlatched axes snap to the nearer bound.
                    if (!x_lat_q && !x_in) begin
                        x_rand_d = (lfsr_x_q < XMIN) ? XMIN : XMAX;
                        x_lat_d  = 1'b1;
                    end
                    if (!y_lat_q && !y_in) begin
                        y_rand_d = (lfsr_y_q < YMIN) ? YMIN : YMAX;
                        y_lat_d  = 1'b1;
                    end
                    fallback_d = 1'b1;
                end else begin
                    try_d = try_q + TW'(1);
                end
            end
        end else if (state_q == S_DONE && Ack) begin
            fallback_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr_x_q   <= XSEED;
            lfsr_y_q   <= YSEED;
            x_rand_q   <= '0;
            y_rand_q   <= '0;
            fallback_q <= 1'b0;
            x_lat_q    <= 1'b0;
            y_lat_q    <= 1'b0;
            try_q      <= '0;
        end else begin
            lfsr_x_q   <= lfsr_x_d;
            lfsr_y_q   <= lfsr_y_d;
            x_rand_q   <= x_rand_d;
            y_rand_q   <= y_rand_d;
            fallback_q <= fallback_d;
            x_lat_q    <= x_lat_d;
            y_lat_q    <= y_lat_d;
            try_q      <= try_d;
        end
    end

    assign X_rand   = x_rand_q;
    assign Y_rand   = y_rand_q;
    assign Fallback = fallback_q;

endmodule

// File: tb/tb_constrained_rand_point_gen.sv
// Testbench for constrained_rand_point_gen: a reference model of the
// sampling algorithm feeds a scoreboard queue at each request.
module tb_constrained_rand_point_gen;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Seed_load = 1'b0;
    logic       Req = 1'b0;
    logic       Ack = 1'b0;
    logic [9:0] X_seed = '0;
    logic [9:0] Y_seed = '0;
    logic       Valid, Fallback, Busy;
    logic [9:0] X_rand, Y_rand;
    logic       Valid2, Fallback2, Busy2;
    logic [9:0] X_rand2, Y_rand2;

    constrained_rand_point_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .Seed_load(Seed_load),
        .X_seed(X_seed), .Y_seed(Y_seed), .Req(Req), .Ack(Ack),
        .Valid(Valid), .X_rand(X_rand), .Y_rand(Y_rand),
        .Fallback(Fallback), .Busy(Busy)
    );

    constrained_rand_point_gen #(.MAX_TRIES(2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Seed_load(Seed_load),
        .X_seed(X_seed), .Y_seed(Y_seed), .Req(Req), .Ack(Ack),
        .Valid(Valid2), .X_rand(X_rand2), .Y_rand(Y_rand2),
        .Fallback(Fallback2), .Busy(Busy2)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       fb;
        int         n;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] mx, my;
    int         tests = 0;
    int         fails = 0;

    function automatic logic [9:0] step(input logic [9:0] s);
        return s[0] ? ((s >> 1) ^ 10'h240) : (s >> 1);
    endfunction

    function automatic exp_t model(input logic [9:0] sx, input logic [9:0] sy, input int mt,
                                   output logic [9:0] nx, output logic [9:0] ny);
        exp_t e;
        bit lx;
        bit ly;
        logic [9:0] cx;
        logic [9:0] cy;
        lx = 0; ly = 0; cx = sx; cy = sy;
        e.x = '0; e.y = '0; e.fb = 1'b0; e.n = 0;
        for (int t = 0; t < mt; t++) begin
            e.n = t + 1;
            if (!lx && cx >= 10'd120 && cx <= 10'd520) begin e.x = cx; lx = 1; end
            if (!ly && cy >= 10'd48 && cy <= 10'd448) begin e.y = cy; ly = 1; end
            if (!(lx && ly) && t == mt - 1) begin
                if (!lx) e.x = (cx < 10'd120) ? 10'd120 : 10'd520;
                if (!ly) e.y = (cy < 10'd48) ? 10'd48 : 10'd448;
                e.fb = 1'b1;
                lx = 1; ly = 1;
            end
            cx = step(cx);
            cy = step(cy);
            if (lx && ly) break;
        end
        nx = cx;
        ny = cy;
        return e;
    endfunction

    task automatic load_seed(input logic [9:0] x, input logic [9:0] y);
        X_seed = x; Y_seed = y; Seed_load = 1'b1;
        @(posedge Clk); #1;
        Seed_load = 1'b0;
        mx = (x == 0) ? 10'd1 : x;
        my = (y == 0) ? 10'd1 : y;
    endtask

    task automatic push_expected();
        logic [9:0] nx, ny;
        exp_t e;
        e = model(mx, my, 16, nx, ny);
        sb.push_back(e);
        mx = nx;
        my = ny;
    endtask

    task automatic issue_req();
        push_expected();
        Req = 1'b1;
        @(posedge Clk); #1;
        Req = 1'b0;
    endtask

    // Waits (bounded) for Valid and returns the presented point and latency in edges.
    task automatic collect(output logic [9:0] gx, output logic [9:0] gy, output logic gf,
                           output int lat);
        lat = 0;
        while (Valid !== 1'b1 && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        gx = X_rand; gy = Y_rand; gf = Fallback;
    endtask

    task automatic do_ack();
        Ack = 1'b1;
        @(posedge Clk); #1;
        Ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] gx, gy;
        logic gf;
        int lat;
        exp_t e;
        #1;
        tests++;
        if ({Valid, X_rand, Y_rand, Fallback, Busy} !== 23'd0) begin
            fails++;
            $display("FAIL reset_state got v=%b x=%0d y=%0d fb=%b busy=%b want all 0",
                     Valid, X_rand, Y_rand, Fallback, Busy);
        end
        #11 Reset_n = 1'b1;
        mx = 10'd1; my = 10'd2;
        @(posedge Clk); #1;
        issue_req();
        repeat (3) @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        tests++;
        if ({Valid, X_rand, Y_rand, Fallback, Busy} !== 23'd0) begin
            fails++;
            $display("FAIL async_reset_mid_search got v=%b x=%0d y=%0d fb=%b busy=%b want all 0",
                     Valid, X_rand, Y_rand, Fallback, Busy);
        end
        sb.delete();
        #3 Reset_n = 1'b1;
        mx = 10'd1; my = 10'd2;
        @(posedge Clk); #1;
        issue_req();
        collect(gx, gy, gf, lat);
        e = sb.pop_front();
        tests++;
        if ({gx, gy, gf} !== {e.x, e.y, e.fb} || lat != e.n) begin
            fails++;
            $display("FAIL post_reset_point got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     gx, gy, gf, lat, e.x, e.y, e.fb, e.n);
        end
        do_ack();
    endtask

    task automatic test_seed_zero();
        logic [9:0] gx, gy;
        logic gf;
        int lat;
        exp_t e;
        load_seed(10'd0, 10'd0);
        issue_req();
        collect(gx, gy, gf, lat);
        e = sb.pop_front();
        tests++;
        if ({gx, gy, gf} !== {e.x, e.y, e.fb} || lat != e.n || gx !== 10'd288) begin
            fails++;
            $display("FAIL seed_zero_point got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     gx, gy, gf, lat, e.x, e.y, e.fb, e.n);
        end
        Req = 1'b1;
        load_seed(10'd200, 10'd200);
        Req = 1'b0;
        tests++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || Fallback !== 1'b0) begin
            fails++;
            $display("FAIL seed_load_in_done got v=%b busy=%b fb=%b want v=0 busy=0 fb=0",
                     Valid, Busy, Fallback);
        end
    endtask

    task automatic test_single_edge();
        logic [9:0] gx, gy;
        logic gf;
        int lat;
        exp_t e;
        load_seed(10'd200, 10'd200);
        issue_req();
        tests++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_search got %b want 1", Busy);
        end
        collect(gx, gy, gf, lat);
        e = sb.pop_front();
        tests++;
        if ({gx, gy, gf} !== {10'd200, 10'd200, 1'b0} || lat != 1 || e.n != 1) begin
            fails++;
            $display("FAIL single_edge_point got x=%0d y=%0d fb=%b lat=%0d want x=200 y=200 fb=0 lat=1",
                     gx, gy, gf, lat);
        end
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_done got %b want 0", Busy);
        end
        do_ack();
    endtask

    task automatic test_fallback();
        logic [9:0] nx, ny;
        exp_t e1, e2;
        int l1, l2;
        logic [9:0] x1, y1, x2, y2;
        logic f1, f2;
        l1 = -1; l2 = -1;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; f1 = 1'b0; f2 = 1'b0;
        load_seed(10'd5, 10'd200);
        e2 = model(10'd5, 10'd200, 2, nx, ny);
        issue_req();
        e1 = sb.pop_front();
        for (int c = 1; c <= 20 && (l1 < 0 || l2 < 0); c++) begin
            @(posedge Clk); #1;
            if (l1 < 0 && Valid === 1'b1) begin l1 = c; x1 = X_rand; y1 = Y_rand; f1 = Fallback; end
            if (l2 < 0 && Valid2 === 1'b1) begin l2 = c; x2 = X_rand2; y2 = Y_rand2; f2 = Fallback2; end
        end
        tests++;
        if ({x1, y1, f1} !== {e1.x, e1.y, e1.fb} || l1 != e1.n || x1 !== 10'd289) begin
            fails++;
            $display("FAIL retry_point got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     x1, y1, f1, l1, e1.x, e1.y, e1.fb, e1.n);
        end
        tests++;
        if ({x2, y2, f2} !== {e2.x, e2.y, e2.fb} || l2 != e2.n || {x2, f2} !== {10'd520, 1'b1}) begin
            fails++;
            $display("FAIL clamp_point got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     x2, y2, f2, l2, e2.x, e2.y, e2.fb, e2.n);
        end
        do_ack();
        tests++;
        if (Valid2 !== 1'b0 || Fallback2 !== 1'b0 || X_rand2 !== 10'd520) begin
            fails++;
            $display("FAIL clamp_ack got v=%b fb=%b x=%0d want v=0 fb=0 x=520", Valid2, Fallback2, X_rand2);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] gx, gy;
        logic gf;
        int lat;
        exp_t e;
        load_seed(10'd200, 10'd200);
        issue_req();
        collect(gx, gy, gf, lat);
        e = sb.pop_front();
        tests++;
        if ({gx, gy, gf} !== {e.x, e.y, e.fb} || lat != e.n) begin
            fails++;
            $display("FAIL b2b_first got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     gx, gy, gf, lat, e.x, e.y, e.fb, e.n);
        end
        Req = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if (Valid !== 1'b1 || Busy !== 1'b0 || {X_rand, Y_rand, Fallback} !== {gx, gy, gf}) begin
            fails++;
            $display("FAIL req_without_ack_hold got v=%b busy=%b x=%0d y=%0d want v=1 busy=0 x=%0d y=%0d",
                     Valid, Busy, X_rand, Y_rand, gx, gy);
        end
        push_expected();
        Ack = 1'b1;
        @(posedge Clk); #1;
        Ack = 1'b0;
        Req = 1'b0;
        tests++;
        if (Valid !== 1'b0 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_valid_drop got v=%b busy=%b want v=0 busy=1", Valid, Busy);
        end
        collect(gx, gy, gf, lat);
        e = sb.pop_front();
        tests++;
        if ({gx, gy, gf} !== {e.x, e.y, e.fb} || lat != e.n || {gx, gy} !== {10'd294, 10'd100}) begin
            fails++;
            $display("FAIL b2b_second got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     gx, gy, gf, lat, e.x, e.y, e.fb, e.n);
        end
        do_ack();
        tests++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || {X_rand, Y_rand} !== {gx, gy}) begin
            fails++;
            $display("FAIL ack_to_idle got v=%b busy=%b x=%0d y=%0d want v=0 busy=0 x=%0d y=%0d",
                     Valid, Busy, X_rand, Y_rand, gx, gy);
        end
        Ack = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Ack = 1'b0;
        tests++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || {X_rand, Y_rand} !== {gx, gy}) begin
            fails++;
            $display("FAIL ack_in_idle got v=%b busy=%b x=%0d y=%0d want v=0 busy=0 x=%0d y=%0d",
                     Valid, Busy, X_rand, Y_rand, gx, gy);
        end
        // LFSRs held in IDLE, so the next request continues the same sequence.
        issue_req();
        collect(gx, gy, gf, lat);
        e = sb.pop_front();
        tests++;
        if ({gx, gy, gf} !== {e.x, e.y, e.fb} || lat != e.n) begin
            fails++;
            $display("FAIL continued_sequence got x=%0d y=%0d fb=%b lat=%0d want x=%0d y=%0d fb=%b lat=%0d",
                     gx, gy, gf, lat, e.x, e.y, e.fb, e.n);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_seed_zero();
        test_single_edge();
        test_fallback();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
